// File: rtl/jtoutrun_obj_buf.sv
// rtl/jtoutrun_obj_buf.sv - double-buffered object line buffer between the OutRun object drawer and the colour mixer
//
// Purpose: the drawer builds line N+1 in the "draw" half while line N is read
// out of the "scan" half at pixel rate; each read column is cleared to CLRVAL
// on the following clk. Halves swap on hstart.
//
// Ports:
//   clk      in   1   system clock
//   rst      in   1   synchronous active-high reset
//   hstart   in   1   line-start strobe, swaps halves at the end of its clk
//   pxl_cen  in   1   readout enable
//   hdump    in   9   readout column
//   bf_data  in  14   drawer pixel {pal[6:0], shadow, prio[1:0], colour[3:0]}
//   bf_we    in   1   drawer write strobe
//   bf_addr  in   9   drawer write column
//   pxl      out 14   pixel for hdump, valid one clk after pxl_cen
//   half     out  1   current draw-half select (0: draw A / scan B)
//
// Optional macro JTOUTRUN_OBJPRIO_EN: drawer writes become a two-stage
// read-compare-write that only overwrites transparent or lower/equal priority pixels.

module jtoutrun_obj_buf #(
  parameter logic [13:0] CLRVAL    = 14'h000F,
  parameter logic        SWAP_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hstart,
  input  logic        pxl_cen,
  input  logic [8:0]  hdump,
  input  logic [13:0] bf_data,
  input  logic        bf_we,
  input  logic [8:0]  bf_addr,
  output logic [13:0] pxl,
  output logic        half
);

  // RAM select encoding: 0 = A, 1 = B. The draw half is half_q, scan is ~half_q.
  logic [13:0] ram_a [512];
  logic [13:0] ram_b [512];

  logic        half_q, half_d;
  logic [13:0] pxl_q;
  logic        clr_pend_q;
  logic [8:0]  clr_addr_q;
  logic        clr_sel_q;
  logic        clr_en;

  // Resolved draw-side write port
  logic        dw_en;
  logic [8:0]  dw_addr;
  logic [13:0] dw_data;
  logic        dw_sel;

  assign half_d = hstart ? ~half_q : half_q;
  // A clear still due when rst arrives is dropped
  assign clr_en = clr_pend_q & ~rst;

`ifdef JTOUTRUN_OBJPRIO_EN
  logic        s2_vld_q;
  logic [8:0]  s2_addr_q;
  logic [13:0] s2_data_q;
  logic [13:0] s2_old_q;
  logic        s2_sel_q;
  logic        s2_take;
  logic [13:0] s1_old;

  always_comb begin
    s2_take = s2_vld_q && ((s2_old_q[3:0] == 4'hF) || (s2_data_q[5:4] >= s2_old_q[5:4]));
    s1_old  = half_q ? ram_b[bf_addr] : ram_a[bf_addr];
    // The stage-2 result lands at this same edge, so the RAM read is stale:
    // forward whatever stage 2 leaves behind in that column.
    if (s2_vld_q && (s2_addr_q == bf_addr) && (s2_sel_q == half_q))
      s1_old = s2_take ? s2_data_q : s2_old_q;
    dw_en   = s2_take;
    dw_addr = s2_addr_q;
    dw_data = s2_data_q;
    dw_sel  = s2_sel_q;  // captured at stage 1, so an in-flight write survives a swap
  end

  always_ff @(posedge clk) begin
    if (rst) s2_vld_q <= 1'b0;
    else     s2_vld_q <= bf_we;
    s2_addr_q <= bf_addr;
    s2_data_q <= bf_data;
    s2_old_q  <= s1_old;
    s2_sel_q  <= half_q;
  end
`else
  always_comb begin
    dw_en   = bf_we;
    dw_addr = bf_addr;
    dw_data = bf_data;
    dw_sel  = half_q;
  end
`endif

  // Clear of the last column read on a line can land on the new draw half right
  // after a swap; both writes are kept and the drawer wins on the same column.
  always_ff @(posedge clk) begin
    if (clr_en && !clr_sel_q) ram_a[clr_addr_q] <= CLRVAL;
    if (dw_en  && !dw_sel)    ram_a[dw_addr]    <= dw_data;
    if (clr_en &&  clr_sel_q) ram_b[clr_addr_q] <= CLRVAL;
    if (dw_en  &&  dw_sel)    ram_b[dw_addr]    <= dw_data;
  end

  // Readout and clear bookkeeping. The read samples the RAM before this edge's
  // clear write, giving read-before-write when hdump repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_q     <= SWAP_INIT;
      pxl_q      <= CLRVAL;
      clr_pend_q <= 1'b0;
    end else begin
      half_q     <= half_d;
      if (pxl_cen) pxl_q <= half_q ? ram_a[hdump] : ram_b[hdump];
      clr_pend_q <= pxl_cen;
    end
    clr_addr_q <= hdump;
    clr_sel_q  <= ~half_q;
  end

  assign pxl  = pxl_q;
  assign half = half_q;

endmodule

// File: tb/tb_jtoutrun_obj_buf.sv
// tb/tb_jtoutrun_obj_buf.sv - self-checking bench for jtoutrun_obj_buf
module tb_jtoutrun_obj_buf;

  localparam logic [13:0] CLR = 14'h000F;
`ifdef JTOUTRUN_OBJPRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hstart = 1'b0;
  logic        pxl_cen = 1'b0;
  logic [8:0]  hdump = '0;
  logic [13:0] bf_data = '0;
  logic        bf_we = 1'b0;
  logic [8:0]  bf_addr = '0;
  logic [13:0] pxl;
  logic        half;

  always #5 clk = ~clk;

  jtoutrun_obj_buf dut (
    .clk(clk), .rst(rst), .hstart(hstart), .pxl_cen(pxl_cen), .hdump(hdump),
    .bf_data(bf_data), .bf_we(bf_we), .bf_addr(bf_addr), .pxl(pxl), .half(half)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-level model: two column arrays (index 0 = A, 1 = B), a known flag per
  // column for contents not yet defined since power-up, and the displayed pixel.
  logic [13:0] m_mem   [2][512];
  bit          m_known [2][512];
  bit          m_half = 1'b0;
  logic [13:0] m_pxl = CLR;
  bit          m_pxl_known = 1'b0;
  bit          m_pend = 1'b0;
  int          m_pa = 0;
  bit          m_ps = 1'b0;
  bit          m_started = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_half = 1'b0; m_pxl = CLR; m_pxl_known = 1'b1; m_pend = 1'b0; m_started = 1'b1;
    end else begin
      logic [13:0] cur;
      bit          scan;
      scan = !m_half;
      if (pxl_cen) begin
        m_pxl = m_mem[scan][hdump];
        m_pxl_known = m_known[scan][hdump];
      end
      if (m_pend) begin
        m_mem[m_ps][m_pa] = CLR; m_known[m_ps][m_pa] = 1'b1;
      end
      m_pend = pxl_cen; m_pa = int'(hdump); m_ps = scan;
      if (bf_we) begin
        cur = m_mem[m_half][bf_addr];
        if (!PRIO || bf_data[5:4] == 2'd3 ||
            (m_known[m_half][bf_addr] && (cur[3:0] == 4'hF || bf_data[5:4] >= cur[5:4]))) begin
          m_mem[m_half][bf_addr] = bf_data; m_known[m_half][bf_addr] = 1'b1;
        end
      end
      if (hstart) m_half = !m_half;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("half_model", {13'b0, half}, {13'b0, m_half});
      if (m_pxl_known) chk("pxl_model", pxl, m_pxl);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic wr(input logic [8:0] a, input logic [13:0] d);
    bf_we = 1'b1; bf_addr = a; bf_data = d; tick(); bf_we = 1'b0;
  endtask
  task automatic hs();
    hstart = 1'b1; tick(); hstart = 1'b0;
  endtask
  task automatic rd(input logic [8:0] a);
    pxl_cen = 1'b1; hdump = a; tick(); pxl_cen = 1'b0;
  endtask
  task automatic full_pass();
    pxl_cen = 1'b1;
    for (int i = 0; i < 512; i++) begin
      hdump = 9'(i); tick();
    end
    pxl_cen = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle(2); rst = 1'b0;
    chk("reset_pxl", pxl, CLR);
    chk("reset_half", {13'b0, half}, 14'h0);

    // Basic write, swap, read, then clear-after-read
    hs(); wr(9'h0A0, 14'h1234); idle(3); hs();
    rd(9'h0A0); idle(1); chk("t1_read", pxl, 14'h1234);
    hs(); hs(); rd(9'h0A0); idle(1); chk("t1_cleared", pxl, CLR);

    // Write in the hstart cycle lands in the half displayed next
    bf_we = 1'b1; bf_addr = 9'h100; bf_data = 14'h0AB1; hstart = 1'b1; tick();
    bf_we = 1'b0; hstart = 1'b0;
    idle(3); rd(9'h100); idle(1); chk("t2_same_clk_hstart", pxl, 14'h0AB1);

    // Full line fill, back-to-back readout, second pass reads cleared pixels
    for (int i = 0; i < 512; i++) wr(9'(i), 14'(i + 'h40));
    idle(3); hs(); full_pass(); idle(1); chk("t3_last_col", pxl, 14'h023F);
    hs(); full_pass(); idle(1);
    hs(); full_pass(); idle(1); chk("t3_second_pass", pxl, CLR);

    // Back-to-back writes to one column
    wr(9'h050, 14'h0015); wr(9'h050, 14'h0027); idle(3); hs();
    rd(9'h050); idle(1); chk("t4_last_wins", pxl, 14'h0027);

    // Priority ordering (outcome depends on the optional feature)
    wr(9'h060, 14'h0025); wr(9'h060, 14'h0017);
    wr(9'h070, 14'h0017); wr(9'h070, 14'h0025);
    idle(3); hs();
    rd(9'h060); idle(1); chk("t5_hi_then_lo", pxl, PRIO ? 14'h0025 : 14'h0017);
    rd(9'h070); idle(1); chk("t5_lo_then_hi", pxl, 14'h0025);

    // Reset between a read and its clear
    wr(9'h1F0, 14'h0333); idle(3); hs();
    chk("t6_half_before", {13'b0, half}, 14'h1);
    pxl_cen = 1'b1; hdump = 9'h1F0; tick(); pxl_cen = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_rst_half", {13'b0, half}, 14'h0);
    chk("t6_rst_pxl", pxl, CLR);
    hs(); rd(9'h1F0); idle(1); chk("t6_clear_aborted", pxl, 14'h0333);

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
